// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int INSTR_W  = 32;
    localparam int OPCODE_W = 6;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_FULL
    } fetch_state_e;

endpackage

// File: rtl/fetch_out_buf.sv
// One-entry valid/ready buffer holding the fetched word and its pc+4 for the decoder.
module fetch_out_buf
    import fetch_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load,
    input  logic                flush,
    input  logic                ready,
    input  logic [INSTR_W-1:0]  instr_in,
    input  logic [31:0]         pc_plus4_in,
    output logic                valid,
    output logic [INSTR_W-1:0]  instr,
    output logic [OPCODE_W-1:0] opcode,
    output logic [31:0]         pc_plus4
);

    // NOTE: payload registers are reset too, so the decoder never sees X before the first fetch.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid    <= 1'b0;
            instr    <= '0;
            pc_plus4 <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid    <= 1'b1;
            instr    <= instr_in;
            pc_plus4 <= pc_plus4_in;
        end else if (ready && valid) begin
            valid <= 1'b0;
        end
    end

    assign opcode = instr[INSTR_W-1 -: OPCODE_W];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register and request/response FSM feeding a one-entry output buffer.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                clk_i,
    input  logic                rst_i,
    output logic                imem_req_o,
    output logic [31:0]         imem_addr_o,
    input  logic                imem_gnt_i,
    input  logic                imem_rvalid_i,
    input  logic [INSTR_W-1:0]  imem_rdata_i,
    output logic                instr_valid_o,
    output logic [INSTR_W-1:0]  instr_o,
    output logic [OPCODE_W-1:0] instr_op_o,
    output logic [31:0]         pc_plus4_o,
    input  logic                instr_ready_i,
    input  logic                redirect_i,
    input  logic [31:0]         redirect_pc_i
);

    fetch_state_e state;
    logic [31:0]  pc;
    logic         drop;
    logic [31:0]  pc_inc;
    logic [31:0]  target_pc;
    logic         buf_load;
    logic         buf_flush;
    logic         unused_redirect_lsbs;

    assign target_pc            = {redirect_pc_i[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];
    assign pc_inc               = pc + 32'd4;

    assign imem_req_o  = (state == ST_REQ);
    assign imem_addr_o = pc;

    // A response only reaches the decoder if no redirect made it stale.
    assign buf_load  = (state == ST_WAIT) && imem_rvalid_i && !drop && !redirect_i;
    assign buf_flush = (state == ST_FULL) && redirect_i;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
            pc    <= RESET_PC;
            drop  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (redirect_i) pc <= target_pc;
                    state <= ST_REQ;
                end
                ST_REQ: begin
                    if (redirect_i) begin
                        pc <= target_pc;
                        // A grant in this cycle was for the old address.
                        if (imem_gnt_i) begin
                            state <= ST_WAIT;
                            drop  <= 1'b1;
                        end
                    end else if (imem_gnt_i) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (redirect_i) begin
                        pc <= target_pc;
                        if (imem_rvalid_i) begin
                            drop  <= 1'b0;
                            state <= ST_REQ;
                        end else begin
                            drop <= 1'b1;
                        end
                    end else if (imem_rvalid_i) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= ST_REQ;
                        end else begin
                            pc    <= pc_inc;
                            state <= ST_FULL;
                        end
                    end
                end
                ST_FULL: begin
                    if (redirect_i) begin
                        pc    <= target_pc;
                        state <= ST_REQ;
                    end else if (instr_ready_i) begin
                        state <= ST_REQ;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    fetch_out_buf u_out_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load        (buf_load),
        .flush       (buf_flush),
        .ready       (instr_ready_i),
        .instr_in    (imem_rdata_i),
        .pc_plus4_in (pc_inc),
        .valid       (instr_valid_o),
        .instr       (instr_o),
        .opcode      (instr_op_o),
        .pc_plus4    (pc_plus4_o)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Random and directed stimulus for instr_fetch_unit, checked against a transaction-level fetch model.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic                imem_req_o;
    logic [31:0]         imem_addr_o;
    logic                imem_gnt_i;
    logic                imem_rvalid_i;
    logic [INSTR_W-1:0]  imem_rdata_i;
    logic                instr_valid_o;
    logic [INSTR_W-1:0]  instr_o;
    logic [OPCODE_W-1:0] instr_op_o;
    logic [31:0]         pc_plus4_o;
    logic                instr_ready_i;
    logic                redirect_i;
    logic [31:0]         redirect_pc_i;

    always #5 clk_i = ~clk_i;

    instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_op_o    (instr_op_o),
        .pc_plus4_o    (pc_plus4_o),
        .instr_ready_i (instr_ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Instruction memory contents: a distinct word per address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    // Transaction-level model: the address stream the fetcher should walk,
    // the single outstanding bus transaction, and the decoder-side buffer.
    bit          m_idle;
    bit          m_out;
    bit          m_stale;
    bit          m_buf;
    logic [31:0] m_fetch;
    logic [31:0] m_exp;
    logic [31:0] m_out_addr;

    function automatic bit m_req();
        return !m_idle && !m_out && !m_buf;
    endfunction

    task automatic model_reset();
        m_idle     = 1'b1;
        m_out      = 1'b0;
        m_stale    = 1'b0;
        m_buf      = 1'b0;
        m_fetch    = RST_PC;
        m_exp      = RST_PC;
        m_out_addr = RST_PC;
    endtask

    task automatic compare_outputs();
        logic [31:0] w;
        check("req", 32'(imem_req_o), 32'(m_req()));
        if (m_req()) check("addr", imem_addr_o, m_fetch);
        check("valid", 32'(instr_valid_o), 32'(m_buf));
        if (m_buf) begin
            w = mem_word(m_exp);
            check("instr", instr_o, w);
            check("opcode", 32'(instr_op_o), 32'(w[31:26]));
            check("pc_plus4", pc_plus4_o, m_exp + 32'd4);
        end
    endtask

    // One clock: compare on the falling edge, drive inputs, then advance the model at the rising edge.
    task automatic cycle(input bit gnt, input bit rv, input bit rdy, input bit redir,
                         input logic [31:0] tgt);
        bit          req_now;
        logic [31:0] tgt_al;
        @(negedge clk_i);
        compare_outputs();
        req_now       = m_req();
        tgt_al        = tgt & 32'hFFFF_FFFC;
        imem_gnt_i    = gnt;
        imem_rvalid_i = rv;
        imem_rdata_i  = m_out ? mem_word(m_out_addr) : $urandom();
        instr_ready_i = rdy;
        redirect_i    = redir;
        redirect_pc_i = tgt;
        @(posedge clk_i);
        m_idle = 1'b0;
        if (redir) begin
            if (m_out && rv) begin
                m_out = 1'b0;
            end else if (m_out) begin
                m_stale = 1'b1;
            end else if (req_now && gnt) begin
                m_out      = 1'b1;
                m_stale    = 1'b1;
                m_out_addr = m_fetch;
            end
            m_buf   = 1'b0;
            m_fetch = tgt_al;
            m_exp   = tgt_al;
        end else begin
            if (m_out && rv) begin
                m_out = 1'b0;
                if (!m_stale) m_buf = 1'b1;
                m_stale = 1'b0;
            end else if (req_now && gnt) begin
                m_out      = 1'b1;
                m_stale    = 1'b0;
                m_out_addr = m_fetch;
                m_fetch    = m_fetch + 32'd4;
            end else if (m_buf && rdy) begin
                m_buf = 1'b0;
                m_exp = m_exp + 32'd4;
            end
        end
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_req"},      32'(imem_req_o), 32'd0);
        check({pfx, "_addr"},     imem_addr_o, RST_PC);
        check({pfx, "_valid"},    32'(instr_valid_o), 32'd0);
        check({pfx, "_instr"},    instr_o, 32'd0);
        check({pfx, "_opcode"},   32'(instr_op_o), 32'd0);
        check({pfx, "_pc_plus4"}, pc_plus4_o, 32'd0);
    endtask

    initial begin
        bit          g, v, r, d;
        logic [31:0] t;

        rst_i         = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        instr_ready_i = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1 check_reset_values("rst");
        #1 rst_i = 1'b1;

        // Zero-wait memory with the decoder always ready: 0x100, 0x104, 0x108.
        repeat (10) cycle(1, 1, 1, 0, 32'h0);

        // Back-pressure: buffer held for five cycles.
        cycle(1, 0, 0, 0, 32'h0);
        cycle(0, 1, 0, 0, 32'h0);
        repeat (5) cycle(0, 0, 0, 0, 32'h0);
        cycle(0, 0, 1, 0, 32'h0);

        // Redirect while waiting on 0x10: its data must never surface.
        cycle(0, 0, 0, 1, 32'h0000_0010);
        cycle(1, 0, 0, 0, 32'h0);
        cycle(0, 0, 0, 1, 32'h0000_2003);
        cycle(0, 1, 1, 0, 32'h0);
        cycle(1, 0, 1, 0, 32'h0);
        cycle(0, 1, 1, 0, 32'h0);
        cycle(0, 0, 1, 0, 32'h0);

        // Redirect and grant in the same cycle.
        cycle(1, 0, 0, 1, 32'h0000_0040);
        cycle(0, 1, 0, 0, 32'h0);
        cycle(1, 0, 0, 0, 32'h0);
        cycle(0, 1, 0, 0, 32'h0);

        // Redirect wins over a simultaneous ready while full.
        cycle(0, 0, 1, 1, 32'h0000_0800);
        cycle(0, 0, 0, 0, 32'h0);

        // PC wrap at the top of the address space.
        cycle(0, 0, 0, 1, 32'hFFFF_FFFC);
        cycle(1, 0, 0, 0, 32'h0);
        cycle(0, 1, 0, 0, 32'h0);
        #1 check("wrap_pc_plus4", pc_plus4_o, 32'h0);
        cycle(0, 0, 1, 0, 32'h0);
        #1 check("wrap_next_addr", imem_addr_o, 32'h0);
        check("wrap_next_req", 32'(imem_req_o), 32'd1);

        // Asynchronous reset in the middle of a fetch, then a stale response.
        cycle(1, 0, 0, 0, 32'h0);
        #2 rst_i = 1'b0;
        #1 check_reset_values("async_rst");
        imem_rvalid_i = 1'b1;
        model_reset();
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        repeat (4) cycle(0, 1, 0, 0, 32'h0);
        cycle(1, 0, 0, 0, 32'h0);
        cycle(0, 1, 0, 0, 32'h0);
        cycle(0, 0, 1, 0, 32'h0);

        // Randomised handshakes and redirects.
        for (int i = 0; i < 3000; i++) begin
            g = ($urandom_range(99) < 60);
            v = ($urandom_range(99) < 40);
            r = ($urandom_range(99) < 70);
            d = ($urandom_range(99) < 8);
            if ($urandom_range(3) == 0) t = 32'hFFFF_FFF0 | 32'($urandom_range(15));
            else                        t = $urandom();
            cycle(g, v, r, d, t);
        end

        @(negedge clk_i);
        compare_outputs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage directly upstream of the opcode decoder. Holds the PC, fetches one 32-bit word at a time from instruction memory over a request/grant/response handshake, and presents it with `pc+4` to the decoder through a one-entry valid/ready output buffer. Branch/jump redirects from execute override sequential fetch, and any in-flight stale fetch is squashed.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC value loaded at reset; bits [1:0] must be 0.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `imem_req_o`  out  1  fetch request.
- `imem_addr_o`  out  32  fetch address, equal to current PC.
- `imem_gnt_i`  in  1  request accepted this cycle.
- `imem_rvalid_i`  in  1  response data valid.
- `imem_rdata_i`  in  32  instruction word.
- `instr_valid_o`  out  1  output buffer holds a valid instruction.
- `instr_o`  out  32  buffered instruction.
- `instr_op_o`  out  6  `instr_o[31:26]`, wired to the decoder opcode input.
- `pc_plus4_o`  out  32  address of buffered instruction + 4.
- `instr_ready_i`  in  1  decoder accepts the buffered instruction.
- `redirect_i`  in  1  taken branch/jump.
- `redirect_pc_i`  in  32  redirect target; bits [1:0] are ignored and forced to 0.

## Operation
- FSM states: IDLE, REQ, WAIT, FULL. Reset enters IDLE; IDLE → REQ unconditionally on the next edge.
- REQ: `imem_req_o`=1, `imem_addr_o`=PC. On `imem_gnt_i`, go to WAIT.
- WAIT: `imem_req_o`=0. On `imem_rvalid_i` with the drop flag clear:
  - load `instr_o`=`imem_rdata_i` and `pc_plus4_o`=PC+4;
  - set PC to PC+4;
  - go to FULL.
- WAIT, `imem_rvalid_i` with the drop flag set: discard the data, clear drop, go to REQ. The PC is not incremented.
- FULL: `instr_valid_o`=1. On `instr_ready_i`, clear valid and go to REQ.
- Redirect has highest priority. In every state it sets PC to `{redirect_pc_i[31:2],2'b00}` and has these additional effects:
  - REQ without gnt: stay in REQ; the new address is driven next cycle.
  - REQ with gnt in the same cycle: the grant belongs to the old address. Go to WAIT with drop set.
  - WAIT: set drop and stay in WAIT. If `imem_rvalid_i` arrives in the same cycle, discard the data and go to REQ.
  - FULL: clear `instr_valid_o` and go to REQ. Flushing has priority over a simultaneous `instr_ready_i`; the decoder must treat that word as squashed.
  - IDLE: load the target PC and go to REQ.
- Only one request is outstanding at a time. `imem_rvalid_i` outside WAIT is ignored.
- PC arithmetic is modulo 2^32: PC `32'hFFFF_FFFC` + 4 wraps to 0 with no error.

## Timing
- Reset values (asynchronous):
  - state=IDLE, PC=`RESET_PC`, drop=0;
  - `imem_req_o`=0, `imem_addr_o`=`RESET_PC`;
  - `instr_valid_o`=0, `instr_o`=0, `instr_op_o`=0, `pc_plus4_o`=0.
- `imem_req_o` and `imem_addr_o` are decoded from registered state and PC only, never combinationally from inputs.
- `instr_*` and `pc_plus4_o` are registered.
- With zero-wait memory (gnt in the same cycle as req, rvalid on the next cycle), the sequence per instruction is REQ → WAIT → FULL → REQ. Peak throughput is one instruction per 3 cycles with `instr_ready_i` held at 1.
- Redirect-to-request latency is 1 cycle: assert `redirect_i` in cycle N, and the target appears on `imem_addr_o` with req=1 in cycle N+1. The exception is WAIT, where the request waits for the stale response to drain.
- Reset asserted mid-operation aborts immediately: the drop flag clears and any later stale `imem_rvalid_i` is ignored, because the FSM is in IDLE/REQ.

## Structure
- Package `fetch_pkg` holds:
  - the FSM state enum (IDLE, REQ, WAIT, FULL);
  - `INSTR_W`=32 and `OPCODE_W`=6;
  - the default reset-PC constant.
- Sub-module `fetch_out_buf` is the one-entry valid/ready buffer, with load, flush and ready inputs. The PC register and FSM stay in the top module.

## Test plan
- Reset with `RESET_PC`=`32'h0000_0100`, zero-wait memory, ready=1 → addresses 0x100, 0x104, 0x108 issued. Each word appears on `instr_o` with `pc_plus4_o`=0x104, 0x108, 0x10C; `instr_op_o` equals bits [31:26].
- Hold `instr_ready_i`=0 for 5 cycles while FULL → `instr_valid_o` stays 1, `instr_o` is stable, `imem_req_o`=0 throughout.
- Assert `redirect_i` with target 0x2003 while in WAIT for address 0x10 → the response for 0x10 is discarded and never valid on output. The next request is to 0x2000.
- Assert redirect and gnt in the same REQ cycle, target 0x40 → one response is dropped, the next request is to 0x40, and the PC is not incremented by the dropped word.
- Redirect with `instr_ready_i`=1 while FULL → valid drops next cycle, and the following request is to the target.
- PC=`32'hFFFF_FFFC` fetch → `pc_plus4_o`=0 and the next request address is 0. Then assert `rst_i`=0 during WAIT → all outputs return to their reset values asynchronously.
